// File: rtl/capture_ctrl.sv
// Pre/post-trigger capture sequencer: passes a sample stream through to a memory
// writer, framing a window of cfg_pre beats before a trigger and cfg_post beats from it.
module capture_ctrl #(
  parameter int SDW = 32,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CW-1:0]  cfg_pre,
  input  logic [CW-1:0]  cfg_post,
  input  logic           ctl_arm,
  input  logic           ctl_abort,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic           sti_trigger,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic [SDW-1:0] sto_tdata,
  output logic           ind_arm,
  output logic           ind_trg,
  output logic           sts_done,
  output logic [2:0]     sts_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FILL = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] POST = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] pre_q, pre_d;
  logic [CW-1:0] post_q, post_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trg_q, trg_d;

  logic          active;
  logic          accept;
  logic          last_beat;
  logic [CW-1:0] cnt_inc;

  // Stream is a pure combinational pass-through while capturing; otherwise input is drained.
  assign active     = (state_q == FILL) || (state_q == WAIT) || (state_q == POST);
  assign sti_tready = active ? sto_tready : 1'b1;
  assign sto_tvalid = active & sti_tvalid;
  assign sto_tdata  = sti_tdata;
  assign accept     = active & sti_tvalid & sti_tready;
  assign cnt_inc    = cnt_q + CW'(1);

  assign last_beat = accept &&
                     (((state_q == WAIT) && sti_trigger && (post_q == CW'(1))) ||
                      ((state_q == POST) && (cnt_inc == post_q)));

  assign sto_tlast = last_beat;
  assign ind_arm   = (state_q == FILL) || (state_q == WAIT);
  assign ind_trg   = trg_q;
  assign sts_done  = (state_q == DONE);
  assign sts_state = state_q;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    post_d  = post_q;
    cnt_d   = cnt_q;
    trg_d   = trg_q;
    case (state_q)
      IDLE: begin
        if (ctl_arm) begin
          pre_d   = cfg_pre;
          post_d  = (cfg_post == '0) ? CW'(1) : cfg_post;
          cnt_d   = '0;
          trg_d   = 1'b0;
          state_d = (cfg_pre == '0) ? WAIT : FILL;
        end
      end
      FILL: begin
        // Abort acts as a forced trigger; the beat on that cycle still flows but is not counted.
        if (ctl_abort) begin
          trg_d   = 1'b1;
          cnt_d   = '0;
          state_d = POST;
        end else if (accept) begin
          if (cnt_inc == pre_q) begin
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT: begin
        if (accept && sti_trigger) begin
          trg_d = 1'b1;
          if (post_q == CW'(1)) begin
            state_d = DONE;
          end else begin
            cnt_d   = CW'(1);
            state_d = POST;
          end
        end else if (ctl_abort) begin
          trg_d   = 1'b1;
          cnt_d   = '0;
          state_d = POST;
        end
      end
      POST: begin
        if (accept) begin
          if (cnt_inc == post_q) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      post_q  <= '0;
      cnt_q   <= '0;
      trg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      cnt_q   <= cnt_d;
      trg_q   <= trg_d;
    end
  end

endmodule
